roe_sequencer: RTL and testbench
================================

Name: roe_sequencer

Overview:
- Multi-cycle sequencer for the R.O.E 9-bit datapath. It owns the PC and the instruction register, and steps each instruction through FETCH, EXEC, optional MEM, and WB.
- Gates register-file and data-memory strobes coming from the combinational decoder, so that each strobe fires exactly once per instruction.
- Sits between instruction memory, the decoder, the data-memory port and the register file.

Parameters:
- PC_W, 10, PC width in bits; instruction memory depth is 2**PC_W.
- HALT_INSTR, 9'h1FF, instruction encoding that stops the sequencer.
- START_PC, 0, PC value loaded on reset and on start.
- MEM_TIMEOUT, 15, maximum dmem_ready wait in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins execution at START_PC
- imem_rdata  in  9  instruction word at pc; valid on the cycle after imem_req
- imem_req  out  1  instruction fetch strobe
- pc  out  PC_W  current program counter
- ir  out  9  latched instruction, fed to the decoder
- dec_reg_write  in  1  decoder register-write request
- dec_mem_read  in  1  decoder load request
- dec_mem_write  in  1  decoder store request
- branch_taken  in  1  from the ALU in EXEC
- branch_target  in  PC_W  target PC, sampled when branch_taken=1 in EXEC
- dmem_req  out  1  data-memory request, held high until ready
- dmem_we  out  1  qualifies dmem_req as a store
- dmem_ready  in  1  data-memory completion
- reg_we  out  1  gated register-file write enable
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- err  out  1  sticky memory-timeout flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=START_PC, ir=0.
  - imem_req, dmem_req, dmem_we, reg_we, busy, halted, err all 0.
  - Reset asserted mid-instruction abandons the instruction immediately; no strobe may persist past the reset edge.
- States: IDLE, FETCH, LATCH, EXEC, MEM, WB, HALT. All outputs are registered or decoded from state only.
- IDLE: on start=1, pc<=START_PC, go to FETCH. start is ignored in all other states.
- FETCH: imem_req=1 for exactly one cycle, then go to LATCH.
- LATCH: ir<=imem_rdata.
  - If imem_rdata==HALT_INSTR, go to HALT.
  - Otherwise go to EXEC.
- EXEC: one cycle; the decoder is combinational on ir.
  - If dec_mem_read or dec_mem_write: go to MEM.
  - Else if dec_reg_write: go to WB.
  - Else: complete the instruction (PC update, then FETCH).
- MEM:
  - dmem_req=1, with dmem_we=dec_mem_write.
  - dec_mem_read and dec_mem_write both high: treat as a store (dmem_we=1).
  - Stay in MEM until dmem_ready=1.
  - On the dmem_ready cycle: go to WB if dec_mem_read, else complete.
  - dmem_ready outside MEM is ignored.
- WB: reg_we=1 for exactly one cycle, then complete.
- PC update on completion:
  - Captured in EXEC: next_pc = branch_taken ? branch_target : pc+1.
  - Applied on leaving the final state of the instruction, then go to FETCH.
  - pc+1 wraps modulo 2**PC_W; all-ones wraps to 0 with no error.
- Latencies:
  - ALU-only, no writeback: 3 cycles (FETCH, LATCH, EXEC).
  - ALU with writeback: 4 cycles.
  - Load: 5+w cycles, where w is the number of MEM cycles with dmem_ready=0.
  - Store: 4+w cycles.
- HALT: halted=1, busy=0. Only reset leaves HALT; start is ignored.
- reg_we and dmem_req are never high in the same cycle.

Optional Feature:
- Macro: ROE_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs while in MEM, cleared on entry to MEM.
  - If MEM_TIMEOUT cycles elapse without dmem_ready, set err=1 (sticky until reset), drop dmem_req, and go to HALT.
  - dmem_ready arriving on exactly the MEM_TIMEOUT-th cycle counts as success.
- Undefined:
  - MEM waits indefinitely.
  - err is tied to 0.
  - No counter logic is synthesized.

Test Plan:
- Reset and halt:
  - Stimulus: rst_n low, then high; start pulse; imem holds HALT_INSTR at address 0.
  - Required: all outputs 0 after reset; imem_req one cycle; halted=1 two cycles after FETCH; pc stays 0; further start pulses ignored.
- ALU writeback:
  - Stimulus: instruction at pc=0 with dec_reg_write=1, no memory.
  - Required: reg_we pulses once in cycle 4 after FETCH; pc=1 at the next FETCH; dmem_req never asserts.
- Load with wait states:
  - Stimulus: dec_mem_read=1; dmem_ready low 3 cycles, then high.
  - Required: dmem_req high 4 cycles with dmem_we=0; then reg_we one cycle; total 8 cycles; pc increments by 1.
- Taken branch and wrap:
  - Stimulus: at pc=10'h3FF, no branch; then branch_taken=1 with branch_target=10'h005.
  - Required: next pc=0 (wrap); after the branch instruction, pc=5; reg_we and dmem_req stay 0.
- Reset mid-MEM:
  - Stimulus: store in MEM holding dmem_req=1; drop rst_n asynchronously.
  - Required: dmem_req and dmem_we go to 0 without a clock edge; state=IDLE; pc=START_PC.
- Timeout (ROE_SEQ_TIMEOUT_EN defined, MEM_TIMEOUT=15):
  - Stimulus: dmem_ready held low.
  - Required: after 15 MEM cycles, err=1 and halted=1, and dmem_req drops.
  - Rerun with dmem_ready high on cycle 15: normal completion, err=0.

Source files
------------

// File: rtl/roe_sequencer.sv
// rtl/roe_sequencer.sv - multi-cycle FETCH/LATCH/EXEC/MEM/WB sequencer for the R.O.E 9-bit datapath
// Optional MEM wait timeout enabled by defining ROE_SEQ_TIMEOUT_EN.
module roe_sequencer #(
    parameter int                PC_W        = 10,
    parameter logic [8:0]        HALT_INSTR  = 9'h1FF,
    parameter logic [PC_W-1:0]   START_PC    = '0,
    parameter int                MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [8:0]      imem_rdata,
    output logic            imem_req,
    output logic [PC_W-1:0] pc,
    output logic [8:0]      ir,
    input  logic            dec_reg_write,
    input  logic            dec_mem_read,
    input  logic            dec_mem_write,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    output logic            reg_we,
    output logic            busy,
    output logic            halted,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] next_pc_q, next_pc_d;
    logic [8:0]      ir_q, ir_d;
    logic            store_q, store_d;
    logic            load_q, load_d;
    logic            imem_req_q, imem_req_d;
    logic            dmem_req_q, dmem_req_d;
    logic            dmem_we_q, dmem_we_d;
    logic            reg_we_q, reg_we_d;
    logic            busy_q, busy_d;
    logic            halted_q, halted_d;

`ifdef ROE_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        next_pc_d = next_pc_q;
        ir_d      = ir_q;
        store_d   = store_q;
        load_d    = load_q;
`ifdef ROE_SEQ_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = START_PC;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                ir_d    = imem_rdata;
                state_d = (imem_rdata == HALT_INSTR) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                next_pc_d = branch_taken ? branch_target : pc_q + 1'b1;
                // A simultaneous read+write decodes as a store with no writeback.
                store_d   = dec_mem_write;
                load_d    = dec_mem_read & ~dec_mem_write;
                if (dec_mem_read || dec_mem_write) begin
                    state_d = S_MEM;
`ifdef ROE_SEQ_TIMEOUT_EN
                    cnt_d   = CNT_W'(1);
`endif
                end else if (dec_reg_write) begin
                    state_d = S_WB;
                end else begin
                    pc_d    = next_pc_d;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (load_q) begin
                        state_d = S_WB;
                    end else begin
                        pc_d    = next_pc_q;
                        state_d = S_FETCH;
                    end
                end
`ifdef ROE_SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_WB: begin
                pc_d    = next_pc_q;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies of the next-state decode.
        imem_req_d = (state_d == S_FETCH);
        dmem_req_d = (state_d == S_MEM);
        dmem_we_d  = (state_d == S_MEM) && store_d;
        reg_we_d   = (state_d == S_WB);
        busy_d     = (state_d != S_IDLE) && (state_d != S_HALT);
        halted_d   = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= START_PC;
            next_pc_q  <= START_PC;
            ir_q       <= '0;
            store_q    <= 1'b0;
            load_q     <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            reg_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
`ifdef ROE_SEQ_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            next_pc_q  <= next_pc_d;
            ir_q       <= ir_d;
            store_q    <= store_d;
            load_q     <= load_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            reg_we_q   <= reg_we_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
`ifdef ROE_SEQ_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign imem_req = imem_req_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign dmem_req = dmem_req_q;
    assign dmem_we  = dmem_we_q;
    assign reg_we   = reg_we_q;
    assign busy     = busy_q;
    assign halted   = halted_q;
`ifdef ROE_SEQ_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_roe_sequencer.sv
// tb/tb_roe_sequencer.sv - table-driven and directed checks for roe_sequencer
module tb_roe_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] imem_rdata = '0;
    logic       imem_req;
    logic [9:0] pc;
    logic [8:0] ir;
    logic       dec_reg_write, dec_mem_read, dec_mem_write, branch_taken;
    logic [9:0] branch_target;
    logic       dmem_req, dmem_we;
    logic       dmem_ready = 1'b0;
    logic       reg_we, busy, halted, err;

    logic [8:0] imem [0:1023];

    int checks = 0;
    int errors = 0;

    // Run statistics collected by run_prog
    int n_busy, n_reg, n_dmem, n_we, n_imem, n_overlap, halt_at;
    bit done;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= imem[pc];

    // Toy decoder: bit0 reg_write, bit1 mem_read, bit2 mem_write, bit3 branch,
    // bits 8:4 sign-extended branch target.
    assign dec_reg_write = ir[0];
    assign dec_mem_read  = ir[1];
    assign dec_mem_write = ir[2];
    assign branch_taken  = ir[3];
    assign branch_target = {{5{ir[8]}}, ir[8:4]};

    roe_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_rdata(imem_rdata), .imem_req(imem_req), .pc(pc), .ir(ir),
        .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
        .dec_mem_write(dec_mem_write), .branch_taken(branch_taken),
        .branch_target(branch_target), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ready(dmem_ready), .reg_we(reg_we), .busy(busy),
        .halted(halted), .err(err)
    );

    typedef struct {
        logic [8:0] instr;
        int         wait_cycles;
        int         exp_cycles;
        int         exp_reg;
        int         exp_dmem;
        int         exp_we;
        logic [9:0] exp_pc;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) imem[i] = 9'h000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        dmem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pulses start, then samples at each negedge until halted or limit cycles.
    task automatic run_prog(input int wait_cycles, input int limit);
        int memcyc;
        n_busy = 0; n_reg = 0; n_dmem = 0; n_we = 0; n_imem = 0;
        n_overlap = 0; halt_at = -1; done = 0; memcyc = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (busy) n_busy++;
            if (reg_we) n_reg++;
            if (dmem_req) n_dmem++;
            if (dmem_we) n_we++;
            if (imem_req) n_imem++;
            if (reg_we && dmem_req) n_overlap++;
            if (dmem_req) begin
                memcyc++;
                dmem_ready = (memcyc == wait_cycles + 1);
            end else begin
                dmem_ready = 1'b0;
            end
            if (halted) begin
                halt_at = c;
                done = 1;
                break;
            end
            @(negedge clk);
        end
        dmem_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{9'h000, 0, 3, 0, 0, 0, 10'h001};  // ALU only
        vecs[1] = '{9'h001, 0, 4, 1, 0, 0, 10'h001};  // ALU writeback
        vecs[2] = '{9'h002, 3, 8, 1, 4, 0, 10'h001};  // load, 3 waits
        vecs[3] = '{9'h002, 0, 5, 1, 1, 0, 10'h001};  // load, no wait
        vecs[4] = '{9'h004, 2, 6, 0, 3, 3, 10'h001};  // store, 2 waits
        vecs[5] = '{9'h006, 1, 5, 0, 2, 2, 10'h001};  // read+write acts as store
        vecs[6] = '{9'h058, 0, 3, 0, 0, 0, 10'h005};  // taken branch
        vecs[7] = '{9'h059, 0, 4, 1, 0, 0, 10'h005};  // branch with writeback
        vecs[8] = '{9'h05A, 1, 6, 1, 2, 0, 10'h005};  // load with branch

        clear_imem();
        #2;
        check("reset_outputs", {imem_req, dmem_req, dmem_we, reg_we, busy, halted, err}, 7'b0);
        check("reset_pc", pc, 10'h000);
        check("reset_ir", ir, 9'h000);
        do_reset();
        repeat (4) @(negedge clk);
        check("idle_no_start_busy", {busy, imem_req}, 2'b00);

        // Table-driven single instructions followed by HALT
        for (int v = 0; v < 9; v++) begin
            clear_imem();
            imem[0] = vecs[v].instr;
            imem[vecs[v].exp_pc] = 9'h1FF;
            do_reset();
            run_prog(vecs[v].wait_cycles, 100);
            check($sformatf("v%0d_done", v), done, 1'b1);
            check($sformatf("v%0d_cycles", v), n_busy, vecs[v].exp_cycles + 2);
            check($sformatf("v%0d_reg_we", v), n_reg, vecs[v].exp_reg);
            check($sformatf("v%0d_dmem_req", v), n_dmem, vecs[v].exp_dmem);
            check($sformatf("v%0d_dmem_we", v), n_we, vecs[v].exp_we);
            check($sformatf("v%0d_imem_req", v), n_imem, 2);
            check($sformatf("v%0d_overlap", v), n_overlap, 0);
            check($sformatf("v%0d_pc", v), pc, vecs[v].exp_pc);
            check($sformatf("v%0d_err", v), err, 1'b0);
        end

        // Immediate HALT at address 0, then start is ignored
        clear_imem();
        imem[0] = 9'h1FF;
        do_reset();
        run_prog(0, 20);
        check("halt_imem_req_once", n_imem, 1);
        check("halt_at_cycle", halt_at, 2);
        check("halt_pc", pc, 10'h000);
        check("halt_busy", busy, 1'b0);
        run_prog(0, 6);
        check("halt_restart_ignored_imem", n_imem, 0);
        check("halt_restart_busy", n_busy, 0);
        check("halt_still_halted", halted, 1'b1);

        // Branch to 0x3FF, ALU op there wraps pc to 0, then branch to 5
        clear_imem();
        imem[0]      = 9'h1F8;
        imem[10'h3FF] = 9'h000;
        imem[5]      = 9'h1FF;
        do_reset();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        begin
            int c;
            c = 0;
            while (pc != 10'h3FF && c < 20) begin @(negedge clk); c++; end
            check("wrap_reach_3ff", pc, 10'h3FF);
            imem[0] = 9'h058;
            c = 0;
            while (pc == 10'h3FF && c < 20) begin @(negedge clk); c++; end
            check("wrap_to_zero", pc, 10'h000);
            n_reg = 0; n_dmem = 0;
            c = 0;
            while (!halted && c < 20) begin
                if (reg_we) n_reg++;
                if (dmem_req) n_dmem++;
                @(negedge clk); c++;
            end
            check("wrap_halted", halted, 1'b1);
            check("wrap_branch_pc", pc, 10'h005);
            check("wrap_no_strobes", n_reg + n_dmem, 0);
        end

        // Asynchronous reset while a store waits in MEM
        clear_imem();
        imem[0] = 9'h004;
        do_reset();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        begin
            int c;
            c = 0;
            while (!dmem_req && c < 10) begin @(negedge clk); c++; end
            check("rmem_in_mem", {dmem_req, dmem_we}, 2'b11);
            #2 rst_n = 1'b0;
            #1;
            check("rmem_strobes_cleared", {dmem_req, dmem_we, reg_we, imem_req}, 4'b0);
            check("rmem_idle", {busy, halted}, 2'b00);
            check("rmem_pc", pc, 10'h000);
            @(negedge clk) rst_n = 1'b1;
        end

`ifdef ROE_SEQ_TIMEOUT_EN
        clear_imem();
        imem[0] = 9'h004;
        do_reset();
        run_prog(1000, 60);
        check("tmo_halted", done, 1'b1);
        check("tmo_mem_cycles", n_dmem, 15);
        check("tmo_err", err, 1'b1);
        check("tmo_dmem_dropped", dmem_req, 1'b0);

        clear_imem();
        imem[0] = 9'h004;
        imem[1] = 9'h1FF;
        do_reset();
        run_prog(14, 60);
        check("tmo_edge_done", done, 1'b1);
        check("tmo_edge_mem_cycles", n_dmem, 15);
        check("tmo_edge_err", err, 1'b0);
        check("tmo_edge_pc", pc, 10'h001);
`else
        clear_imem();
        imem[0] = 9'h004;
        do_reset();
        run_prog(1000, 40);
        check("notmo_still_waiting", done, 1'b0);
        check("notmo_dmem_req", dmem_req, 1'b1);
        check("notmo_err", err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
